// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin grant scheduler.
package arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam int N_REQ_DEF    = 8;
   localparam int HOLD_MAX_DEF = 16;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_priority_pick #(
   parameter int N_REQ = 8,
   parameter int IDX_W = 3
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] winner,
   output logic             any_req
);

   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   logic [IDX_W-1:0]   off;

   always_comb begin
      // Doubling the vector turns the circular rotate into a plain shift.
      dbl = {req, req} >> ptr;
      rot = dbl[N_REQ-1:0];
      off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) off = IDX_W'(i);
      end
      // N_REQ is a power of two, so the add wraps modulo N_REQ for free.
      winner  = off + ptr;
      any_req = |req;
   end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin arbiter with held grants, owner release and optional hold timeout.
module rr_grant_scheduler
   import arb_pkg::*;
#(
   parameter int N_REQ    = N_REQ_DEF,
   parameter int IDX_W    = idx_width(N_REQ),
   parameter int HOLD_MAX = HOLD_MAX_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             preempt
);

   localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   // With the timeout disabled the counter just saturates at all-ones.
   localparam logic [CNT_W-1:0] CNT_TOP = (HOLD_MAX == 0) ? {CNT_W{1'b1}} : CNT_W'(HOLD_MAX - 1);

   state_t           state;
   logic [IDX_W-1:0] ptr;
   logic [CNT_W-1:0] hold_cnt;
   logic [IDX_W-1:0] idx_q;
   logic             valid_q;
   logic             preempt_q;

   logic [IDX_W-1:0] winner;
   logic             any_req;
   logic             owner_req;
   logic             timeout;
   logic             rel;

   rr_priority_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req     (req),
      .ptr     (ptr),
      .winner  (winner),
      .any_req (any_req)
   );

   always_comb begin
      owner_req = req[idx_q];
      timeout   = (HOLD_MAX != 0) && (hold_cnt == CNT_TOP);
      rel       = done | ~owner_req | timeout;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         hold_cnt  <= '0;
         idx_q     <= '0;
         valid_q   <= 1'b0;
         preempt_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               preempt_q <= 1'b0;
               if (any_req) begin
                  idx_q    <= winner;
                  valid_q  <= 1'b1;
                  hold_cnt <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (rel) begin
                  idx_q     <= '0;
                  valid_q   <= 1'b0;
                  ptr       <= idx_q + 1'b1;
                  state     <= IDLE;
                  // Only a pure timeout counts as a preemption.
                  preempt_q <= timeout & ~done & owner_req;
               end else begin
                  preempt_q <= 1'b0;
                  if (hold_cnt != CNT_TOP) hold_cnt <= hold_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      gnt = '0;
      for (int i = 0; i < N_REQ; i++) begin
         gnt[i] = valid_q && (idx_q == IDX_W'(i));
      end
   end

   assign gnt_idx   = idx_q;
   assign gnt_valid = valid_q;
   assign preempt   = preempt_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler with a cycle-level ownership model.
module tb_rr_grant_scheduler;

   localparam int N  = 8;
   localparam int IW = 3;
   localparam int HM = 4;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  req;
   logic          done;
   logic [N-1:0]  gnt;
   logic [IW-1:0] gnt_idx;
   logic          gnt_valid;
   logic          preempt;

   int checks = 0;
   int errors = 0;

   rr_grant_scheduler #(
      .N_REQ    (N),
      .IDX_W    (IW),
      .HOLD_MAX (HM)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .preempt   (preempt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: who owns the resource, how many cycles it has been visible, where search starts.
   int m_owner = -1;
   int m_len   = 0;
   int m_ptr   = 0;
   bit m_pre   = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner = -1;
         m_len   = 0;
         m_ptr   = 0;
         m_pre   = 1'b0;
      end else begin
         m_pre = 1'b0;
         if (m_owner < 0) begin
            bit found;
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
               if (!found && req[(m_ptr + k) % N]) begin
                  found   = 1'b1;
                  m_owner = (m_ptr + k) % N;
                  m_len   = 1;
               end
            end
         end else begin
            bit d, dr, to;
            d  = done;
            dr = !req[m_owner];
            to = (HM != 0) && (m_len == HM);
            if (d || dr || to) begin
               m_pre   = to && !d && !dr;
               m_ptr   = (m_owner + 1) % N;
               m_owner = -1;
               m_len   = 0;
            end else begin
               m_len++;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [N-1:0]  e_gnt;
      logic [IW-1:0] e_idx;
      e_gnt = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      e_idx = (m_owner >= 0) ? IW'(m_owner) : '0;
      checks++;
      if (gnt !== e_gnt || gnt_idx !== e_idx || gnt_valid !== (m_owner >= 0) || preempt !== m_pre) begin
         errors++;
         $display("FAIL model t=%0t: gnt=%h idx=%0d vld=%b pre=%b, expected gnt=%h idx=%0d vld=%b pre=%b",
                  $time, gnt, gnt_idx, gnt_valid, preempt, e_gnt, e_idx, (m_owner >= 0), m_pre);
      end
      checks++;
      if (!$onehot0(gnt)) begin
         errors++;
         $display("FAIL onehot t=%0t: gnt=%h, expected one-hot or zero", $time, gnt);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   int exp2[4] = '{0, 2, 0, 2};

   initial begin
      rst_n = 1'b1;
      req   = '0;
      done  = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("reset_gnt", 32'(gnt), 32'h0);
      chk("reset_vld", 32'(gnt_valid), 32'h0);
      repeat (3) cyc();
      rst_n = 1'b1;

      // 1: idle with no requests
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("t1_idle", {22'(gnt), 8'(gnt_idx), 1'(gnt_valid), 1'(preempt)}, 32'h0);
      end

      // 2: two requesters alternate, owner releases with done
      req = 8'b0000_0101;
      for (int g = 0; g < 4; g++) begin
         cyc();
         chk("t2_idx", 32'(gnt_idx), 32'(exp2[g]));
         chk("t2_vld", 32'(gnt_valid), 32'h1);
         cyc();
         done = 1'b1;
         cyc();
         chk("t2_gap", 32'(gnt), 32'h0);
         done = 1'b0;
      end
      req = '0;
      cyc();

      // 3: ptr wraps 7 -> 0
      req = 8'h80;
      cyc();
      chk("t3_first7", 32'(gnt), 32'h80);
      done = 1'b1;
      cyc();
      done = 1'b0;
      req  = 8'h81;
      cyc();
      chk("t3_wrap0", 32'(gnt_idx), 32'h0);
      chk("t3_wrap0_vld", 32'(gnt_valid), 32'h1);
      done = 1'b1;
      cyc();
      done = 1'b0;
      cyc();
      chk("t3_then7", 32'(gnt_idx), 32'h7);
      done = 1'b1;
      cyc();
      done = 1'b0;
      req  = 8'h03;

      // 4: timeout preempts, then the other requester gets its turn
      for (int c = 0; c < HM; c++) begin
         cyc();
         chk("t4_hold0", 32'(gnt), 32'h01);
      end
      cyc();
      chk("t4_pre0", {31'(gnt), preempt}, 32'h1);
      for (int c = 0; c < HM; c++) begin
         cyc();
         chk("t4_hold1", {31'(gnt), preempt}, 32'h04);
      end
      cyc();
      chk("t4_pre1", {31'(gnt), preempt}, 32'h1);
      req = 8'h18;

      // 5: owner 3 drops its request; search resumes from 4
      cyc();
      chk("t5_own3", 32'(gnt_idx), 32'h3);
      cyc();
      req = 8'h12;
      cyc();
      chk("t5_drop", {31'(gnt), preempt}, 32'h0);
      cyc();
      chk("t5_next4", 32'(gnt), 32'h10);

      // 6: async reset mid-grant
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async", {22'(gnt), 8'(gnt_idx), 1'(gnt_valid), 1'(preempt)}, 32'h0);
      req = 8'hFF;
      repeat (2) cyc();
      rst_n = 1'b1;
      cyc();
      chk("t6_restart", 32'(gnt), 32'h01);

      // done on the timeout cycle suppresses preempt
      repeat (HM - 1) cyc();
      done = 1'b1;
      cyc();
      chk("t7_nopre", {31'(gnt), preempt}, 32'h0);
      done = 1'b0;
      req  = '0;
      repeat (3) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
